// File: rtl/arbiter_4req_if.sv
// arbiter_4req_if
// Bundles the request/grant signals between the requesters (master side)
// and the arbiter (slave side).
//   mode    : 0 = fixed priority, 1 = round-robin (sampled when idle)
//   req     : level-held request vector, bit 0 is highest fixed priority
//   done    : single-cycle pulse from the current owner to release
//   gnt     : registered one-hot grant, all zero with no owner
//   gnt_idx : registered encoded owner index, 00 with no owner
//   busy    : OR of gnt
//   timeout : one-cycle pulse marking a release forced by the hold limit
//
// Handshake: a requester raises req[k] and holds it until it sees gnt[k].
// It keeps req[k] high for as long as it wants the resource. It ends
// ownership by pulsing done or by dropping req[k]. Ownership also ends when
// the hold limit is reached. gnt is never reassigned without an all-zero gap
// cycle in between.
interface arbiter_4req_if;
  logic       mode;
  logic [0:3] req;
  logic       done;
  logic [0:3] gnt;
  logic [0:1] gnt_idx;
  logic       busy;
  logic       timeout;

  modport master (
    output mode, req, done,
    input  gnt, gnt_idx, busy, timeout
  );

  modport slave (
    input  mode, req, done,
    output gnt, gnt_idx, busy, timeout
  );
endinterface

// File: rtl/arbiter_4req.sv
// arbiter_4req
// Shares one resource among four requesters, using fixed-priority or
// round-robin selection. Each grant lasts at most MAX_HOLD cycles.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   bus        : arbiter_4req_if.slave (mode/req/done in, gnt/gnt_idx/busy/timeout out)
//   dbg_own_o  : FSM state for observation (1 = OWN, 0 = IDLE)
module arbiter_4req #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  arbiter_4req_if.slave  bus,
  output logic           dbg_own_o
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] owner_q, owner_d;
  logic [0:3] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic       timeout_q, timeout_d;

  logic [1:0] winner;
  logic       at_limit;
  logic       owner_req;

  // Scan four positions from a start point and return the first set one.
  // Fixed priority is the same scan started at position 0.
  function automatic logic [1:0] pick(input logic [0:3] r, input logic rr,
                                      input logic [1:0] p);
    logic [1:0] start;
    logic [1:0] cand;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    start = rr ? p : 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = start + i[1:0];
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  endfunction

  assign winner    = pick(bus.req, bus.mode, ptr_q);
  assign at_limit  = (hold_q == 8'(MAX_HOLD - 1));
  assign owner_req = bus.req[owner_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          state_d        = OWN;
          owner_d        = winner;
          idx_d          = winner;
          gnt_d          = 4'b0000;
          gnt_d[winner]  = 1'b1;
          hold_d         = 8'd0;
          ptr_d          = winner + 2'd1;
        end
      end
      OWN: begin
        if (bus.done || !owner_req || at_limit) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          idx_d     = 2'd0;
          hold_d    = 8'd0;
          // Flag only releases caused by the limit alone. A coinciding done
          // or request drop counts as a normal release.
          timeout_d = !bus.done && owner_req;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      hold_q    <= 8'd0;
      owner_q   <= 2'd0;
      gnt_q     <= 4'b0000;
      idx_q     <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.busy    = |gnt_q;
  assign bus.timeout = timeout_q;
  assign dbg_own_o   = (state_q == OWN);

endmodule

// File: tb/tb_arbiter_4req.sv
module tb_arbiter_4req;

  logic clk;
  logic rst;
  logic dbg_own;

  arbiter_4req_if bus_if ();

  arbiter_4req #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave),
    .dbg_own_o (dbg_own)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after an edge, packed as {gnt[0:3], gnt_idx, busy, timeout}.
  localparam logic [7:0] Z  = 8'b0000_00_0_0;
  localparam logic [7:0] TO = 8'b0000_00_0_1;
  localparam logic [7:0] G0 = 8'b1000_00_1_0;
  localparam logic [7:0] G1 = 8'b0100_01_1_0;
  localparam logic [7:0] G2 = 8'b0010_10_1_0;
  localparam logic [7:0] G3 = 8'b0001_11_1_0;

  typedef struct packed {
    logic       rst;
    logic       mode;
    logic       done;
    logic [3:0] req;
    logic [7:0] exp;
  } step_t;

  logic [7:0] exp_q[$];
  int         n_cmp;
  int         n_err;

  function automatic logic [7:0] observe();
    return {bus_if.gnt, bus_if.gnt_idx, bus_if.busy, bus_if.timeout};
  endfunction

  // ---------------- driver ----------------
  // Drives inputs for the next edge and queues the outputs expected after it.
  task automatic apply(input step_t s);
    rst           = s.rst;
    bus_if.mode   = s.mode;
    bus_if.done   = s.done;
    bus_if.req    = s.req;
    exp_q.push_back(s.exp);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step_t s [6] = '{
      '{1'b1, 1'b1, 1'b1, 4'b1111, Z },
      '{1'b1, 1'b1, 1'b1, 4'b1111, Z },
      '{1'b0, 1'b1, 1'b0, 4'b1111, G0},
      '{1'b1, 1'b1, 1'b0, 4'b1111, Z },
      '{1'b0, 1'b1, 1'b0, 4'b1111, G0},
      '{1'b0, 1'b1, 1'b0, 4'b0000, Z }
    };
    logic [7:0] got, exp;
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      @(posedge clk); #1;
      got = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        $display("FAIL reset step %0d: got %b expected %b", i, got, exp);
        n_err++;
      end
    end
  endtask

  task automatic test_fixed_priority();
    step_t s [6] = '{
      '{1'b0, 1'b0, 1'b0, 4'b1111, G0},
      '{1'b0, 1'b0, 1'b1, 4'b1111, Z },
      '{1'b0, 1'b0, 1'b0, 4'b0110, G1},
      '{1'b0, 1'b0, 1'b1, 4'b0010, Z },
      '{1'b0, 1'b0, 1'b0, 4'b0010, G2},
      '{1'b0, 1'b0, 1'b0, 4'b0000, Z }
    };
    logic [7:0] got, exp;
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      @(posedge clk); #1;
      got = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        $display("FAIL fixed step %0d: got %b expected %b", i, got, exp);
        n_err++;
      end
    end
  endtask

  // Pointer is 3 on entry, so the order 3,0,1,2,3,0 exercises the wrap.
  task automatic test_round_robin();
    logic [7:0] order [6] = '{G3, G0, G1, G2, G3, G0};
    logic [7:0] got, exp;
    for (int i = 0; i < 12; i++) begin
      apply('{1'b0, 1'b1, i[0], 4'b1111, (i[0] ? Z : order[i / 2])});
      @(posedge clk); #1;
      got = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        $display("FAIL round_robin step %0d: got %b expected %b", i, got, exp);
        n_err++;
      end
    end
  endtask

  task automatic test_timeout();
    step_t s [7] = '{
      '{1'b0, 1'b0, 1'b0, 4'b0001, G3},
      '{1'b0, 1'b0, 1'b0, 4'b0001, G3},
      '{1'b0, 1'b0, 1'b0, 4'b0001, G3},
      '{1'b0, 1'b0, 1'b0, 4'b0001, G3},
      '{1'b0, 1'b0, 1'b0, 4'b0001, TO},
      '{1'b0, 1'b0, 1'b0, 4'b0001, G3},
      '{1'b0, 1'b0, 1'b0, 4'b0000, Z }
    };
    logic [7:0] got, exp;
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      @(posedge clk); #1;
      got = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        $display("FAIL timeout step %0d: got %b expected %b", i, got, exp);
        n_err++;
      end
    end
  endtask

  task automatic test_simultaneous();
    step_t s [15] = '{
      '{1'b0, 1'b0, 1'b0, 4'b0001, G3},
      '{1'b0, 1'b0, 1'b0, 4'b0001, G3},
      '{1'b0, 1'b0, 1'b0, 4'b0001, G3},
      '{1'b0, 1'b0, 1'b0, 4'b0001, G3},
      '{1'b0, 1'b0, 1'b1, 4'b0001, Z },   // done at hold limit
      '{1'b0, 1'b0, 1'b0, 4'b0100, G1},
      '{1'b0, 1'b0, 1'b0, 4'b0100, G1},
      '{1'b0, 1'b0, 1'b0, 4'b0000, Z },   // request drop mid-grant
      '{1'b0, 1'b0, 1'b0, 4'b0010, G2},
      '{1'b0, 1'b0, 1'b0, 4'b0010, G2},
      '{1'b0, 1'b0, 1'b0, 4'b0010, G2},
      '{1'b0, 1'b0, 1'b0, 4'b0010, G2},
      '{1'b0, 1'b0, 1'b0, 4'b0000, Z },   // drop at hold limit
      '{1'b0, 1'b0, 1'b0, 4'b1000, G0},
      '{1'b0, 1'b0, 1'b0, 4'b0000, Z }
    };
    logic [7:0] got, exp;
    for (int i = 0; i < 15; i++) begin
      apply(s[i]);
      @(posedge clk); #1;
      got = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        $display("FAIL simultaneous step %0d: got %b expected %b", i, got, exp);
        n_err++;
      end
    end
  endtask

  // Pointer is 1 on entry: the grant after the switch must go to index 1.
  task automatic test_mode_switch();
    step_t s [6] = '{
      '{1'b0, 1'b0, 1'b0, 4'b1111, G0},
      '{1'b0, 1'b1, 1'b0, 4'b1111, G0},
      '{1'b0, 1'b1, 1'b1, 4'b1111, Z },
      '{1'b0, 1'b1, 1'b0, 4'b1111, G1},
      '{1'b0, 1'b1, 1'b1, 4'b1111, Z },
      '{1'b0, 1'b0, 1'b0, 4'b0000, Z }
    };
    logic [7:0] got, exp;
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      @(posedge clk); #1;
      got = observe();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        $display("FAIL mode_switch step %0d: got %b expected %b", i, got, exp);
        n_err++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    bus_if.mode = 1'b1;
    bus_if.done = 1'b1;
    bus_if.req  = 4'b1111;

    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_timeout();
    test_simultaneous();
    test_mode_switch();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
